// File: rtl/fifo_arb_pkg.sv
// Types and width helpers shared by the FIFO write arbiter and its picker.
`timescale 1ns/1ps
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  function automatic int grant_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  function automatic int cnt_w(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after last_grant, wrapping.
`timescale 1ns/1ps
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int GRANT_W = grant_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GRANT_W-1:0] last_grant,
  output logic [GRANT_W-1:0] pick,
  output logic               any_req
);

  logic               found;
  logic [GRANT_W-1:0] cand;

  // Compare-and-subtract keeps the wrap correct for non-power-of-two NUM_REQ.
  function automatic logic [GRANT_W-1:0] wrap_add(input logic [GRANT_W-1:0] base,
                                                  input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return GRANT_W'(sum);
  endfunction

  always_comb begin
    pick    = '0;
    found   = 1'b0;
    cand    = '0;
    any_req = |req;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = wrap_add(last_grant, i);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port between NUM_REQ streams.
//   state | meaning
//   IDLE  | no grant; pick next requester after last_grant
//   BURST | grant_id owns the write port until last, MAX_BURST words, or drop-out
`timescale 1ns/1ps
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  input  logic                          wr_inhibit,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);

  localparam int GRANT_W = grant_w(NUM_REQ);
  localparam int CNT_W   = cnt_w(MAX_BURST);

  arb_state_e         state_q, state_d;
  logic [GRANT_W-1:0] grant_q, grant_d;
  logic [GRANT_W-1:0] last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [GRANT_W-1:0]    pick;
  logic                  any_req;
  logic                  valid_g, last_g, port_ok, xfer;
  logic [DATA_WIDTH-1:0] data_g;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .GRANT_W (GRANT_W)
  ) u_pick (
    .req        (req_valid),
    .last_grant (last_q),
    .pick       (pick),
    .any_req    (any_req)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GRANT_W'(NUM_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    req_ready    = '0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    busy         = 1'b0;
    valid_g      = 1'b0;
    last_g       = 1'b0;
    data_g       = '0;
    port_ok      = !fifo_full && !wr_inhibit;
    xfer         = 1'b0;

    for (int i = 0; i < NUM_REQ; i++) begin
      if (GRANT_W'(i) == grant_q) begin
        valid_g = req_valid[i];
        last_g  = req_last[i];
        data_g  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d = pick;
          cnt_d   = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        busy = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (GRANT_W'(i) == grant_q) req_ready[i] = port_ok;
        end
        xfer = valid_g && port_ok;
        if (xfer) begin
          fifo_wr_en   = 1'b1;
          fifo_wr_data = data_g;
          cnt_d        = cnt_q + CNT_W'(1);
          if (last_g || (cnt_q == CNT_W'(MAX_BURST - 1))) begin
            state_d = IDLE;
            last_d  = grant_q;
          end
        end else if (!valid_g) begin
          // Drop-out ends the burst; a stall (full/inhibit) never does.
          state_d = IDLE;
          last_d  = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant_id = grant_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: queued requester sources, expected-write queue, negedge monitor.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int DW        = 16;
  localparam int MAX_BURST = 4;

  typedef struct packed {
    logic [1:0]    id;
    logic [DW-1:0] data;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_last;
  logic [NUM_REQ*DW-1:0]    req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     fifo_full;
  logic                     wr_inhibit;
  logic                     fifo_wr_en;
  logic [DW-1:0]            fifo_wr_data;
  logic [1:0]               grant_id;
  logic                     busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int wr_cnt   = 0;
  int first_wr = -1;
  int last_wr  = -1;

  logic [NUM_REQ-1:0] en;
  logic [DW:0]        src_q [NUM_REQ][$];
  exp_t               exp_q [$];

  fifo_wr_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MAX_BURST)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_last     (req_last),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .wr_inhibit   (wr_inhibit),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .grant_id     (grant_id),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [DW-1:0] word(input int i, input int k);
    return 16'hA000 | 16'(i << 8) | 16'(k);
  endfunction

  task automatic load(input int i, input logic [DW-1:0] d, input logic l);
    src_q[i].push_back({l, d});
  endtask

  task automatic exp_push(input int i, input logic [DW-1:0] d);
    exp_t e;
    e.id   = 2'(i);
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Requester sources: present queue heads, pop on a handshake seen at the preceding negedge.
  initial begin
    logic [NUM_REQ-1:0] acc;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #2;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!reset) src_q[i].delete();
        else if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (en[i] && src_q[i].size() > 0) begin
          req_valid[i] = 1'b1;
          {req_last[i], req_data[i*DW +: DW]} = src_q[i][0];
        end else begin
          req_valid[i]        = 1'b0;
          req_last[i]         = 1'b0;
          req_data[i*DW +: DW] = '0;
        end
      end
    end
  end

  // Monitor: handshake model plus in-order scoreboard of FIFO writes.
  initial begin
    exp_t               e;
    logic [NUM_REQ-1:0] er;
    logic               ew;
    forever begin
      @(negedge clk);
      er = '0;
      if (busy && !fifo_full && !wr_inhibit) er[grant_id] = 1'b1;
      ew = busy && req_valid[grant_id] && !fifo_full && !wr_inhibit;
      chk("req_ready", 32'(er), 32'(req_ready));
      chk("wr_en", 32'(fifo_wr_en), 32'(ew));
      if (fifo_wr_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual=%0h required=none (t=%0t)", fifo_wr_data, $time);
        end else begin
          e = exp_q.pop_front();
          chk("wr_data", 32'(fifo_wr_data), 32'(e.data));
          chk("wr_grant", 32'(grant_id), 32'(e.id));
        end
        wr_cnt++;
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
      end else begin
        chk("wr_data_gated", 32'(fifo_wr_data), 32'd0);
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset      = 1'b0;
    fifo_full  = 1'b0;
    wr_inhibit = 1'b0;
    en         = '1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    wr_cnt   = 0;
    first_wr = -1;
    last_wr  = -1;
  endtask

  task automatic wait_drain(input string name);
    for (int n = 0; n < 300; n++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && !busy) break;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    reset      = 1'b0;
    fifo_full  = 1'b0;
    wr_inhibit = 1'b0;
    en         = '1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_data", 32'(fifo_wr_data), 32'd0);

    // Single requester 2, three words, last on the third.
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      load(2, word(2, k), k == 2);
      exp_push(2, word(2, k));
    end
    @(negedge clk);
    chk("t1_idle_latency", 32'(busy), 32'd0);
    @(negedge clk);
    chk("t1_grant", 32'(grant_id), 32'd2);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_wr0", 32'(fifo_wr_en), 32'd1);
    @(negedge clk);
    chk("t1_wr1", 32'(fifo_wr_en), 32'd1);
    @(negedge clk);
    chk("t1_wr2", 32'(fifo_wr_en), 32'd1);
    @(negedge clk);
    chk("t1_back_idle", 32'(busy), 32'd0);
    wait_drain("t1_drain");
    chk("t1_count", 32'(wr_cnt), 32'd3);

    // All four requesters continuously valid, no last: 0,1,2,3,0,... bursts of 4.
    do_reset();
    for (int i = 0; i < NUM_REQ; i++)
      for (int k = 0; k < 8; k++) load(i, word(i, k), 1'b0);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NUM_REQ; i++)
        for (int k = 0; k < 4; k++) exp_push(i, word(i, r * 4 + k));
    wait_drain("t2_drain");
    chk("t2_count", 32'(wr_cnt), 32'd32);
    chk("t2_span", 32'(last_wr - first_wr + 1), 32'd39);

    // FIFO full for 5 cycles after 2 words of a 4-word burst.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      load(0, word(0, k), 1'b0);
      exp_push(0, word(0, k));
    end
    @(negedge clk);
    @(negedge clk);
    chk("t3_wr0", 32'(fifo_wr_en), 32'd1);
    @(negedge clk);
    chk("t3_wr1", 32'(fifo_wr_en), 32'd1);
    @(posedge clk);
    #1;
    fifo_full = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("t3_stall_wr", 32'(fifo_wr_en), 32'd0);
      chk("t3_stall_ready", 32'(req_ready), 32'd0);
      chk("t3_stall_grant", 32'(grant_id), 32'd0);
      chk("t3_stall_busy", 32'(busy), 32'd1);
    end
    @(posedge clk);
    #1;
    fifo_full = 1'b0;
    @(negedge clk);
    chk("t3_wr2", 32'(fifo_wr_en), 32'd1);
    @(negedge clk);
    chk("t3_wr3", 32'(fifo_wr_en), 32'd1);
    @(negedge clk);
    chk("t3_end", 32'(busy), 32'd0);
    wait_drain("t3_drain");
    chk("t3_count", 32'(wr_cnt), 32'd4);

    // wr_inhibit toggling every cycle during a burst from requester 1.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      load(1, word(1, k), k == 3);
      exp_push(1, word(1, k));
    end
    for (int n = 0; n < 12; n++) begin
      @(posedge clk);
      #1;
      wr_inhibit = ~wr_inhibit;
    end
    wr_inhibit = 1'b0;
    wait_drain("t4_drain");
    chk("t4_count", 32'(wr_cnt), 32'd4);

    // Requester 1 drops out mid-burst while 3 waits; 3 must win the next arbitration.
    do_reset();
    for (int k = 0; k < 4; k++) load(1, word(1, k), k == 3);
    for (int k = 0; k < 2; k++) load(3, word(3, k), k == 1);
    exp_push(1, word(1, 0));
    exp_push(1, word(1, 1));
    exp_push(3, word(3, 0));
    exp_push(3, word(3, 1));
    exp_push(1, word(1, 2));
    exp_push(1, word(1, 3));
    @(negedge clk);
    @(negedge clk);
    chk("t5_grant1", 32'(grant_id), 32'd1);
    @(negedge clk);
    @(posedge clk);
    #1;
    en[1] = 1'b0;
    @(negedge clk);
    chk("t5_drop_busy", 32'(busy), 32'd1);
    chk("t5_drop_wr", 32'(fifo_wr_en), 32'd0);
    @(posedge clk);
    #1;
    en[1] = 1'b1;
    @(negedge clk);
    chk("t5_bubble", 32'(busy), 32'd0);
    @(negedge clk);
    chk("t5_grant3", 32'(grant_id), 32'd3);
    chk("t5_busy3", 32'(busy), 32'd1);
    wait_drain("t5_drain");
    chk("t5_count", 32'(wr_cnt), 32'd6);

    // Reset mid-burst after one word, then requesters 0 and 2 -> grant 0 first.
    do_reset();
    for (int k = 0; k < 3; k++) load(2, word(2, k), k == 2);
    exp_push(2, word(2, 0));
    @(negedge clk);
    @(negedge clk);
    chk("t6_wr0", 32'(fifo_wr_en), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("t6_rst_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("t6_rst_data", 32'(fifo_wr_data), 32'd0);
    chk("t6_rst_ready", 32'(req_ready), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_grant", 32'(grant_id), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    chk("t6_abandon", 32'(exp_q.size()), 32'd0);
    load(0, 16'h5500, 1'b1);
    load(2, 16'h5502, 1'b1);
    exp_push(0, 16'h5500);
    exp_push(2, 16'h5502);
    @(negedge clk);
    @(negedge clk);
    chk("t6_grant0", 32'(grant_id), 32'd0);
    chk("t6_busy", 32'(busy), 32'd1);
    wait_drain("t6_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
